// File: rtl/snn_fixed_pkg.sv
// snn_fixed_pkg: shared Q-format definitions for the spiking-neuron datapath.
//   - Word/fraction widths and the constants ONE_Q, MAX_S, MIN_S.
//   - sat_add: signed add at one extra bit, clamped to the word range,
//     returning {result, clamped}.
//   - drv_state_t: synaptic driver states. Decay is a per-cycle action,
//     not a state.
package snn_fixed_pkg;

  localparam int SNN_N = 32;
  localparam int SNN_Q = 16;

  localparam logic signed [SNN_N-1:0] ONE_Q = 32'sh0001_0000;
  localparam logic signed [SNN_N-1:0] MAX_S = 32'sh7FFF_FFFF;
  localparam logic signed [SNN_N-1:0] MIN_S = 32'sh8000_0000;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } drv_state_t;

  typedef struct packed {
    logic signed [SNN_N-1:0] result;
    logic                    clamped;
  } sat_res_t;

  // The two top bits of the widened sum disagree exactly when the true
  // result falls outside the N-bit signed range.
  function automatic sat_res_t sat_add(input logic signed [SNN_N-1:0] a,
                                       input logic signed [SNN_N-1:0] b);
    logic signed [SNN_N:0] s;
    sat_res_t              r;
    s = {a[SNN_N-1], a} + {b[SNN_N-1], b};
    if (s[SNN_N] != s[SNN_N-1]) begin
      r.clamped = 1'b1;
      r.result  = s[SNN_N] ? MIN_S : MAX_S;
    end else begin
      r.clamped = 1'b0;
      r.result  = s[SNN_N-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: small synchronous FIFO holding weighted spike events.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write request and data (ignored while full)
//   i_pop             read request (ignored while empty)
//   o_head            entry at the head of the queue
//   o_full, o_empty   occupancy flags, derived from registered pointers
//   o_count           occupied entries (0..DEPTH)
module spike_event_fifo #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [N-1:0]             i_data,
  input  logic                     i_pop,
  output logic [N-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one wrap bit above the index so full and empty differ.
  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic [N-1:0] r_mem [DEPTH];
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // Pointer update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + {{PW{1'b0}}, 1'b1};
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Storage write; contents need no reset since the pointers gate reads
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/synaptic_current_driver.sv
// synaptic_current_driver: buffers weighted spike events and accumulates them
// into a saturating signed Q-format current that decays on every apply.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_spike_valid     event offered
//   i_spike_weight    signed Q-format weight of the offered event
//   o_spike_ready     FIFO can accept (not full)
//   i_apply           neuron-step strobe; decays the current, blocks pops
//   o_i               synaptic current to the neuron core
//   o_busy            events pending
//   o_fifo_count      occupied FIFO entries
//   o_overflow        sticky saturation flag
module synaptic_current_driver
  import snn_fixed_pkg::*;
#(
  parameter int N           = SNN_N,
  parameter int Q           = SNN_Q,
  parameter int DEPTH       = 4,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_spike_valid,
  input  logic [N-1:0]           i_spike_weight,
  output logic                   o_spike_ready,
  input  logic                   i_apply,
  output logic [N-1:0]           o_i,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // The saturating adder lives in the package at a fixed width, so other
  // word formats are not supported by this implementation.
  if (N != SNN_N || Q != SNN_Q) begin : g_fmt_unsupported
  end

  drv_state_t          r_state;
  drv_state_t          w_state_nxt;
  logic signed [N-1:0] r_i;
  logic signed [N-1:0] w_i_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic [N-1:0]        w_head;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_next_occ;
  logic                w_push;
  logic                w_pop;
  logic signed [N-1:0] w_decayed;
  sat_res_t            w_sum;

  // Decay takes priority: an apply cycle never pops.
  assign w_push     = i_spike_valid && !w_full;
  assign w_pop      = !i_apply && !w_empty;
  assign w_next_occ = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
  // Arithmetic shift floors toward -inf, so small negatives reach exactly 0
  // while small positives below 2^DECAY_SHIFT are held.
  assign w_decayed  = r_i - (r_i >>> DECAY_SHIFT);
  assign w_sum      = sat_add(r_i, w_head);

  spike_event_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_data  (i_spike_weight),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Next state follows post-edge occupancy
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_next_occ != {CW{1'b0}}) begin
          w_state_nxt = ACCUM;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_next_occ == {CW{1'b0}}) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Current datapath: decay, accumulate, or hold
  always_comb begin
    w_i_nxt   = r_i;
    w_ovf_nxt = r_ovf;
    if (i_apply) begin
      w_i_nxt = w_decayed;
    end else if (w_pop) begin
      w_i_nxt   = w_sum.result;
      w_ovf_nxt = r_ovf | w_sum.clamped;
    end else begin
      w_i_nxt = r_i;
    end
  end

  // State, current and overflow registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign o_i           = r_i;
  assign o_overflow    = r_ovf;
  assign o_busy        = !w_empty;
  assign o_spike_ready = !w_full;
  assign o_fifo_count  = w_count;

endmodule
